// File: rtl/stage_mem_if.sv
// stage_mem_if: EX->MEM->WB handshake and data bus; fwd_* signals exist only under STAGE_MEM_FWD_EN
interface stage_mem_if;
  logic        allowout, validin, allowin, validout;
  logic [31:0] input_pc, input_alu_result, data_sram_rdata;
  logic [4:0]  input_rf_waddr;
  logic        input_rf_we, input_mem_load;
  logic [2:0]  input_load_op;
  logic [31:0] output_pc, output_rf_wdata;
  logic [4:0]  output_rf_waddr;
  logic        output_rf_we;
`ifdef STAGE_MEM_FWD_EN
  logic        fwd_valid, fwd_stall;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  modport master (
    output allowout, validin, input_pc, input_alu_result, data_sram_rdata,
           input_rf_waddr, input_rf_we, input_mem_load, input_load_op,
    input  allowin, validout, output_pc, output_rf_wdata, output_rf_waddr, output_rf_we,
           fwd_valid, fwd_stall, fwd_waddr, fwd_wdata
  );
  modport slave (
    input  allowout, validin, input_pc, input_alu_result, data_sram_rdata,
           input_rf_waddr, input_rf_we, input_mem_load, input_load_op,
    output allowin, validout, output_pc, output_rf_wdata, output_rf_waddr, output_rf_we,
           fwd_valid, fwd_stall, fwd_waddr, fwd_wdata
  );
`else
  modport master (
    output allowout, validin, input_pc, input_alu_result, data_sram_rdata,
           input_rf_waddr, input_rf_we, input_mem_load, input_load_op,
    input  allowin, validout, output_pc, output_rf_wdata, output_rf_waddr, output_rf_we
  );
  modport slave (
    input  allowout, validin, input_pc, input_alu_result, data_sram_rdata,
           input_rf_waddr, input_rf_we, input_mem_load, input_load_op,
    output allowin, validout, output_pc, output_rf_wdata, output_rf_waddr, output_rf_we
  );
`endif
endinterface

// File: rtl/stage_mem.sv
// stage_mem: MEM stage, waits RESP_LATENCY for SRAM read, extracts load data; fwd port under STAGE_MEM_FWD_EN
module stage_mem #(
  parameter int RESP_LATENCY = 1
) (
  input logic        clk,
  input logic        resetn,
  stage_mem_if.slave bus
);
  localparam logic LAST = 1'(RESP_LATENCY - 1);
  logic        valid, wcnt, held, rf_we, mem_load, readygo, cap;
  logic [31:0] pc, alu_result, rdata_q, word, load_data;
  logic [4:0]  rf_waddr;
  logic [2:0]  load_op;
  logic [7:0]  b8;
  logic [15:0] h16;
  assign readygo = !mem_load | (wcnt == LAST) | held;
  assign bus.validout = valid & readygo;
  assign bus.allowin = !valid | (readygo & bus.allowout);
  assign cap = bus.allowin & bus.validin;
  always_ff @(posedge clk)
    if (!resetn) begin
      valid <= 1'b0;
      wcnt <= 1'b0;
      held <= 1'b0;
      pc <= '0;
      rf_waddr <= '0;
      rf_we <= 1'b0;
      alu_result <= '0;
      mem_load <= 1'b0;
      load_op <= '0;
      rdata_q <= '0;
    end else if (cap) begin
      valid <= 1'b1;
      wcnt <= 1'b0;
      held <= 1'b0;
      pc <= bus.input_pc;
      rf_waddr <= bus.input_rf_waddr;
      rf_we <= bus.input_rf_we;
      alu_result <= bus.input_alu_result;
      mem_load <= bus.input_mem_load;
      load_op <= bus.input_load_op;
    end else begin
      if (bus.validout & bus.allowout) valid <= 1'b0;
      if (valid & mem_load & (wcnt != LAST)) wcnt <= 1'b1;
      // Freeze the response once WB stalls us, since the SRAM bus may move on
      if (valid & mem_load & readygo & !bus.allowout & !held) begin
        rdata_q <= bus.data_sram_rdata;
        held <= 1'b1;
      end
    end
  always_comb begin
    word = held ? rdata_q : bus.data_sram_rdata;
    b8 = word[{alu_result[1:0], 3'b000} +: 8];
    h16 = alu_result[1] ? word[31:16] : word[15:0];
    load_data = load_op == 3'b000 ? {{24{b8[7]}}, b8}
              : load_op == 3'b100 ? {24'b0, b8}
              : load_op == 3'b001 ? {{16{h16[15]}}, h16}
              : load_op == 3'b101 ? {16'b0, h16}
              : word;
  end
  assign bus.output_pc = pc;
  assign bus.output_rf_waddr = rf_waddr;
  assign bus.output_rf_we = valid & rf_we;
  assign bus.output_rf_wdata = mem_load ? load_data : alu_result;
`ifdef STAGE_MEM_FWD_EN
  assign bus.fwd_valid = valid & rf_we & (rf_waddr != 5'd0);
  assign bus.fwd_waddr = rf_waddr;
  assign bus.fwd_wdata = bus.output_rf_wdata;
  assign bus.fwd_stall = valid & mem_load & !readygo;
`endif
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: two DUTs (RESP_LATENCY 1 and 2) on shared stimulus, checked against a transaction-level model
module tb_stage_mem;
  logic clk = 1'b0, resetn = 1'b0;
  logic validin = 1'b0, allowout = 1'b1, we = 1'b0, ld = 1'b0;
  logic [31:0] pc = '0, alu = '0, rdata = '0;
  logic [4:0] wa = '0;
  logic [2:0] op = '0;
  int n_tests = 0, n_fail = 0;
  bit armed = 0;
  always #5 clk = ~clk;

  stage_mem_if b1 ();
  stage_mem_if b2 ();
  stage_mem #(.RESP_LATENCY(1)) u1 (.clk(clk), .resetn(resetn), .bus(b1.slave));
  stage_mem #(.RESP_LATENCY(2)) u2 (.clk(clk), .resetn(resetn), .bus(b2.slave));

  assign b1.validin = validin;  assign b2.validin = validin;
  assign b1.allowout = allowout; assign b2.allowout = allowout;
  assign b1.input_pc = pc;       assign b2.input_pc = pc;
  assign b1.input_alu_result = alu; assign b2.input_alu_result = alu;
  assign b1.data_sram_rdata = rdata; assign b2.data_sram_rdata = rdata;
  assign b1.input_rf_waddr = wa; assign b2.input_rf_waddr = wa;
  assign b1.input_rf_we = we;    assign b2.input_rf_we = we;
  assign b1.input_mem_load = ld; assign b2.input_mem_load = ld;
  assign b1.input_load_op = op;  assign b2.input_load_op = op;

  logic vo[2], ai[2], wo[2], fv[2], fs[2];
  logic [31:0] po[2], wd[2], fd[2];
  logic [4:0] ao[2], fa[2];
  assign vo[0] = b1.validout; assign vo[1] = b2.validout;
  assign ai[0] = b1.allowin;  assign ai[1] = b2.allowin;
  assign wo[0] = b1.output_rf_we; assign wo[1] = b2.output_rf_we;
  assign po[0] = b1.output_pc; assign po[1] = b2.output_pc;
  assign wd[0] = b1.output_rf_wdata; assign wd[1] = b2.output_rf_wdata;
  assign ao[0] = b1.output_rf_waddr; assign ao[1] = b2.output_rf_waddr;
`ifdef STAGE_MEM_FWD_EN
  assign fv[0] = b1.fwd_valid; assign fv[1] = b2.fwd_valid;
  assign fs[0] = b1.fwd_stall; assign fs[1] = b2.fwd_stall;
  assign fd[0] = b1.fwd_wdata; assign fd[1] = b2.fwd_wdata;
  assign fa[0] = b1.fwd_waddr; assign fa[1] = b2.fwd_waddr;
`else
  assign fv[0] = 1'b0; assign fv[1] = 1'b0;
  assign fs[0] = 1'b0; assign fs[1] = 1'b0;
  assign fd[0] = '0; assign fd[1] = '0;
  assign fa[0] = '0; assign fa[1] = '0;
`endif

  // Reference model: one in-flight instruction per DUT, age = cycles spent in MEM
  logic mv[2], mwe[2], mld[2], mh[2];
  logic [31:0] mpc[2], malu[2], mword[2];
  logic [4:0] mwa[2];
  logic [2:0] mop[2];
  int age[2];

  function automatic logic [31:0] ext(logic [2:0] o, logic [1:0] off, logic [31:0] w);
    int v;
    if (o == 3'd0 || o == 3'd4) begin
      v = int'((w >> (8 * off)) & 32'hFF);
      if (o == 3'd0 && v > 127) v -= 256;
    end else if (o == 3'd1 || o == 3'd5) begin
      v = int'((w >> (16 * (off / 2))) & 32'hFFFF);
      if (o == 3'd1 && v > 32767) v -= 65536;
    end else v = int'(w);
    return 32'(v);
  endfunction
  function automatic logic m_rg(int i); return !mld[i] || age[i] >= i; endfunction
  function automatic logic m_vo(int i); return mv[i] && m_rg(i); endfunction
  function automatic logic m_ai(int i); return !mv[i] || (m_rg(i) && allowout); endfunction
  function automatic logic [31:0] m_wd(int i);
    return mld[i] ? ext(mop[i], malu[i][1:0], mh[i] ? mword[i] : rdata) : malu[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("validout%0d", i), 32'(vo[i]), 32'(m_vo(i)));
      chk($sformatf("allowin%0d", i), 32'(ai[i]), 32'(m_ai(i)));
      chk($sformatf("rf_we%0d", i), 32'(wo[i]), 32'(mv[i] && mwe[i]));
      if (m_vo(i)) begin
        chk($sformatf("pc%0d", i), po[i], mpc[i]);
        chk($sformatf("waddr%0d", i), 32'(ao[i]), 32'(mwa[i]));
        chk($sformatf("wdata%0d", i), wd[i], m_wd(i));
      end
`ifdef STAGE_MEM_FWD_EN
      chk($sformatf("fwd_valid%0d", i), 32'(fv[i]), 32'(mv[i] && mwe[i] && mwa[i] != 0));
      chk($sformatf("fwd_stall%0d", i), 32'(fs[i]), 32'(mv[i] && mld[i] && !m_rg(i)));
      if (mv[i] && m_rg(i)) chk($sformatf("fwd_wdata%0d", i), fd[i], m_wd(i));
      if (mv[i]) chk($sformatf("fwd_waddr%0d", i), 32'(fa[i]), 32'(mwa[i]));
`endif
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic r, c, d;
      r = m_rg(i);
      d = mv[i] && r && allowout;
      c = m_ai(i) && validin;
      if (!resetn) begin
        mv[i] = 0; mwe[i] = 0; mld[i] = 0; mh[i] = 0;
        mpc[i] = 0; malu[i] = 0; mword[i] = 0; mwa[i] = 0; mop[i] = 0; age[i] = 0;
      end else if (c) begin
        mv[i] = 1; mpc[i] = pc; mwa[i] = wa; mwe[i] = we; malu[i] = alu;
        mld[i] = ld; mop[i] = op; age[i] = 0; mh[i] = 0;
      end else begin
        if (mv[i] && mld[i] && r && !allowout && !mh[i]) begin
          mh[i] = 1;
          mword[i] = rdata;
        end
        if (d) mv[i] = 0;
        else if (age[i] < 3) age[i]++;
      end
    end
    if (!resetn) armed = 1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (armed) check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic [31:0] p, input logic [4:0] a, input logic w,
                        input logic [31:0] r, input logic l, input logic [2:0] o);
    pc = p; wa = a; we = w; alu = r; ld = l; op = o; validin = 1'b1;
  endtask

  typedef struct { logic [2:0] op; logic [1:0] off; logic [31:0] exp; } vec_t;
  vec_t tv[5];

  initial begin
    tv[0] = '{3'd0, 2'd3, 32'hFFFFFF80};
    tv[1] = '{3'd4, 2'd3, 32'h00000080};
    tv[2] = '{3'd1, 2'd2, 32'hFFFF80FF};
    tv[3] = '{3'd5, 2'd0, 32'h00007F01};
    tv[4] = '{3'd2, 2'd0, 32'h80FF7F01};

    set_in(32'h1c00_0abc, 5'd3, 1'b1, 32'h5555_aaaa, 1'b1, 3'd0);
    resetn = 1'b0;
    tick(); tick();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_validout", 32'(vo[i]), 0);
      chk("rst_allowin", 32'(ai[i]), 1);
      chk("rst_pc", po[i], 0);
      chk("rst_waddr", 32'(ao[i]), 0);
      chk("rst_we", 32'(wo[i]), 0);
      chk("rst_wdata", wd[i], 0);
      chk("rst_fwd", {30'b0, fv[i], fs[i]}, 0);
    end
    resetn = 1'b1; validin = 1'b0;

    set_in(32'h1c00_0010, 5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'd0);
    tick();
    validin = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      chk("alu_validout", 32'(vo[i]), 1);
      chk("alu_wdata", wd[i], 32'h1234_5678);
      chk("alu_we", 32'(wo[i]), 1);
      chk("alu_waddr", 32'(ao[i]), 5);
      chk("alu_pc", po[i], 32'h1c00_0010);
    end
    tick();

    rdata = 32'h80FF_7F01;
    for (int k = 0; k < 5; k++) begin
      set_in(32'h1c00_0100 + 32'(k * 4), 5'd9, 1'b1, {30'h0400_0000, tv[k].off}, 1'b1, tv[k].op);
      tick();
      validin = 1'b0; #1;
      chk($sformatf("ext1_vo_%0d", k), 32'(vo[0]), 1);
      chk($sformatf("ext1_wdata_%0d", k), wd[0], tv[k].exp);
      chk($sformatf("lat2_vo_%0d", k), 32'(vo[1]), 0);
      chk($sformatf("lat2_allowin_%0d", k), 32'(ai[1]), 0);
      tick(); #1;
      chk($sformatf("ext2_vo_%0d", k), 32'(vo[1]), 1);
      chk($sformatf("ext2_wdata_%0d", k), wd[1], tv[k].exp);
      tick();
    end

    set_in(32'h1c00_0200, 5'd7, 1'b1, 32'h0000_1000, 1'b1, 3'd2);
    tick();
    validin = 1'b0; allowout = 1'b0; #1;
    chk("stall_a_vo", 32'(vo[0]), 1);
    chk("stall_a_wdata", wd[0], 32'h80FF_7F01);
    tick();
    rdata = 32'hDEAD_BEEF; #1;
    chk("stall_b_vo", 32'(vo[0]), 1);
    chk("stall_b_wdata", wd[0], 32'h80FF_7F01);
    tick(); #1;
    chk("stall_c_wdata", wd[0], 32'h80FF_7F01);
    chk("stall_c_allowin", 32'(ai[0]), 0);
    allowout = 1'b1; #1;
    chk("stall_go_vo", 32'(vo[0]), 1);
    chk("stall_go_wdata", wd[0], 32'h80FF_7F01);
    tick(); #1;
    chk("stall_left", 32'(vo[0]), 0);

`ifdef STAGE_MEM_FWD_EN
    set_in(32'h1c00_0300, 5'd0, 1'b1, 32'h0000_2000, 1'b1, 3'd2);
    tick();
    validin = 1'b0; #1;
    chk("fwd_r0_1", 32'(fv[0]), 0);
    chk("fwd_r0_2", 32'(fv[1]), 0);
    tick(); tick();
    rdata = 32'h1357_2468;
    set_in(32'h1c00_0304, 5'd7, 1'b1, 32'h0000_2004, 1'b1, 3'd2);
    tick();
    validin = 1'b0; #1;
    chk("fwd_r7_stall", 32'(fs[1]), 1);
    chk("fwd_r7_valid", 32'(fv[1]), 1);
    tick(); #1;
    chk("fwd_r7_stall_clr", 32'(fs[1]), 0);
    chk("fwd_r7_wdata", fd[1], 32'h1357_2468);
    chk("fwd_r7_waddr", 32'(fa[1]), 7);
    tick();
`endif

    for (int n = 0; n < 3000; n++) begin
      resetn = $urandom_range(0, 99) != 0;
      validin = 1'($urandom);
      allowout = $urandom_range(0, 3) != 0;
      pc = $urandom; alu = $urandom; rdata = $urandom;
      wa = 5'($urandom_range(0, 31));
      we = 1'($urandom); ld = 1'($urandom);
      op = 3'($urandom_range(0, 7));
      tick();
    end
    @(negedge clk);
    check_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
